// File: rtl/brick_collide_if.sv
// Frame-strobe and ball/paddle inputs plus collision results of brick_collide,
// bundled for the game logic (master) and the collision engine (slave).
interface brick_collide_if;
  logic        tick;
  logic [9:0]  ballx;
  logic [9:0]  bally;
  logic [9:0]  padx;
  logic [15:0] topbotcol;
  logic [15:0] lrcol;
  logic        padcol;
  logic [2:0]  padang;
  logic [15:0] alive;
  logic [7:0]  score;
  logic        all_clear;

  modport master (
    output tick, ballx, bally, padx,
    input  topbotcol, lrcol, padcol, padang, alive, score, all_clear
  );

  modport slave (
    input  tick, ballx, bally, padx,
    output topbotcol, lrcol, padcol, padang, alive, score, all_clear
  );
endinterface

// File: rtl/brick_collide.sv
// Per-frame ball vs 16-brick field and paddle collision engine, one brick per cycle.
// Optional macro BRICK_REGEN_EN: refill the brick field when the last brick dies.
module brick_collide #(
  parameter logic [9:0] BRICK_Y0 = 10'd20,
  parameter logic [9:0] PAD_Y    = 10'd220
) (
  input  logic            clk,
  input  logic            rst,
  brick_collide_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [9:0]  bx_q, bx_d, by_q, by_d, px_q, px_d;
  logic        hit_q, hit_d, wlr_q, wlr_d;
  logic [3:0]  widx_q, widx_d;
  logic [15:0] tb_q, tb_d, lr_q, lr_d;
  logic        pc_q, pc_d;
  logic [2:0]  pa_q, pa_d;
  logic [15:0] alive_q, alive_d;
  logic [7:0]  score_q, score_d;

  // Span of the brick under test, in 11 bits so edge math never wraps
  logic [10:0] x_lo, x_hi, y_lo, y_hi, bx11, by11, pad_hi;
  logic        in_span, hit_now, lr_now, pc_c;
  logic [5:0]  pdiff;
  logic [2:0]  pa_c;
  logic [15:0] alive_clr;

  always_comb begin
    bx11    = {1'b0, bx_q};
    by11    = {1'b0, by_q};
    x_lo    = {8'd0, idx_q[2:0]} * 11'd40;
    x_hi    = x_lo + 11'd39;
    y_lo    = {1'b0, BRICK_Y0} + (idx_q[3] ? 11'd10 : 11'd0);
    y_hi    = y_lo + 11'd9;
    in_span = (bx11 >= x_lo) && (bx11 <= x_hi) && (by11 >= y_lo) && (by11 <= y_hi);
    hit_now = alive_q[idx_q] && in_span;
    lr_now  = (bx11 == x_lo) || (bx11 == x_hi);

    pad_hi  = {1'b0, px_q} + 11'd39;
    pc_c    = (by_q == PAD_Y - 10'd1) && (bx_q >= px_q) && (bx11 <= pad_hi);
    // Offset is at most 39 on a hit, so the low 6 bits are exact
    pdiff   = bx_q[5:0] - px_q[5:0];
    pa_c    = pc_c ? 3'(pdiff >> 3) : 3'd0;

    alive_clr = alive_q & ~(16'h0001 << widx_q);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bx_d    = bx_q;
    by_d    = by_q;
    px_d    = px_q;
    hit_d   = hit_q;
    wlr_d   = wlr_q;
    widx_d  = widx_q;
    tb_d    = tb_q;
    lr_d    = lr_q;
    pc_d    = pc_q;
    pa_d    = pa_q;
    alive_d = alive_q;
    score_d = score_q;
    unique case (state_q)
      IDLE: if (bus.tick) begin
        state_d = SCAN;
        idx_d   = 4'd0;
        bx_d    = bus.ballx;
        by_d    = bus.bally;
        px_d    = bus.padx;
        hit_d   = 1'b0;
        wlr_d   = 1'b0;
        widx_d  = 4'd0;
      end
      SCAN: begin
        // First hit in index order locks the winner for this frame
        if (hit_now && !hit_q) begin
          hit_d  = 1'b1;
          wlr_d  = lr_now;
          widx_d = idx_q;
        end
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) state_d = REPORT;
      end
      REPORT: begin
        state_d = IDLE;
        tb_d    = (hit_q && !wlr_q) ? (16'h0001 << widx_q) : 16'h0000;
        lr_d    = (hit_q &&  wlr_q) ? (16'h0001 << widx_q) : 16'h0000;
        pc_d    = pc_c;
        pa_d    = pa_c;
        if (hit_q) begin
          score_d = (score_q == 8'd255) ? 8'd255 : score_q + 8'd1;
`ifdef BRICK_REGEN_EN
          alive_d = (alive_clr == 16'h0000) ? 16'hFFFF : alive_clr;
`else
          alive_d = alive_clr;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      bx_q    <= 10'd0;
      by_q    <= 10'd0;
      px_q    <= 10'd0;
      hit_q   <= 1'b0;
      wlr_q   <= 1'b0;
      widx_q  <= 4'd0;
      tb_q    <= 16'h0000;
      lr_q    <= 16'h0000;
      pc_q    <= 1'b0;
      pa_q    <= 3'd0;
      alive_q <= 16'hFFFF;
      score_q <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      px_q    <= px_d;
      hit_q   <= hit_d;
      wlr_q   <= wlr_d;
      widx_q  <= widx_d;
      tb_q    <= tb_d;
      lr_q    <= lr_d;
      pc_q    <= pc_d;
      pa_q    <= pa_d;
      alive_q <= alive_d;
      score_q <= score_d;
    end
  end

  assign bus.topbotcol = tb_q;
  assign bus.lrcol     = lr_q;
  assign bus.padcol    = pc_q;
  assign bus.padang    = pa_q;
  assign bus.alive     = alive_q;
  assign bus.score     = score_q;
  assign bus.all_clear = (alive_q == 16'h0000);
endmodule

// File: doc/brick_collide.md
BRICK_COLLIDE -- requirements
Module: brick_collide

Interface
REQ-001 Parameter BRICK_Y0, default 10'd20: top row of the brick field. Row0 occupies y BRICK_Y0..BRICK_Y0+9; row1 occupies y BRICK_Y0+10..BRICK_Y0+19.
REQ-002 Parameter PAD_Y, default 10'd220: paddle top row. Paddle contact row is PAD_Y-1.
REQ-003 clk  in  1  single system clock; all logic rising-edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 tick  in  1  one-cycle frame strobe, 60 Hz.
REQ-006 ballx  in  10  ball x position (pixel point).
REQ-007 bally  in  10  ball y position (pixel point).
REQ-008 padx  in  10  paddle left edge; paddle spans padx..padx+39.
REQ-009 topbotcol  out  16  one bit per brick; top/bottom face hit this frame.
REQ-010 lrcol  out  16  one bit per brick; left/right face hit this frame.
REQ-011 padcol  out  1  ball on paddle contact row this frame.
REQ-012 padang  out  3  paddle hit segment, 0..4.
REQ-013 alive  out  16  brick present mask, for the renderer.
REQ-014 score  out  8  bricks destroyed.
REQ-015 all_clear  out  1  alive == 0.

Function
REQ-016 Brick i: col = i[2:0], row = i[3]; x span col*40..col*40+39; y span per REQ-001.
REQ-017 FSM states: IDLE, SCAN, REPORT. IDLE->SCAN on tick, latching ballx/bally/padx and clearing idx. SCAN->REPORT when idx==15. REPORT->IDLE unconditionally.
REQ-018 SCAN tests one brick per cycle, idx 0..15. Hit = alive[idx] and latched point inside the brick span.
REQ-019 Hit class: lrcol if x equals span left or right edge, else topbotcol.
REQ-020 At most one brick per frame; the lowest hit idx wins, later hits are ignored.
REQ-021 REPORT loads all collision outputs in one cycle; they then hold until the next REPORT. Latency is tick at cycle T -> outputs valid at T+18.
REQ-022 On a winning hit, REPORT clears alive[idx] and increments score, saturating at 8'd255.
REQ-023 padcol = (y == PAD_Y-1) and padx <= x <= padx+39, using 11-bit add, no wrap.
REQ-024 padang = (x - padx) >> 3, giving 0..4. It is 0 when padcol == 0.
REQ-025 A tick while not in IDLE is ignored.
REQ-026 all_clear is combinational from alive.

Reset
REQ-027 On rst: state = IDLE, idx = 0, alive = 16'hFFFF, score = 0, and topbotcol, lrcol, padcol, padang are all 0.
REQ-028 rst mid-SCAN/REPORT aborts the frame; no alive or score update occurs.

Configuration
REQ-029 BRICK_REGEN_EN defined: in a REPORT where alive would become 0, alive reloads 16'hFFFF instead and score is kept.
REQ-030 BRICK_REGEN_EN undefined: alive stays 0 and all_clear stays 1 until rst.

Verification
REQ-031 Reset, tick with ball (160,100) -> at T+18 all collision outputs 0, alive = FFFF, score = 0.
REQ-032 Ball (45,25), tick -> topbotcol = 16'h0002, alive = FFFD, score = 1; repeat tick -> no hit.
REQ-033 Ball (40,35), tick -> lrcol[9] = 1 only (brick 9 left edge), alive[9] = 0.
REQ-034 padx = 100, ball (125,219) -> padcol = 1, padang = 3; ball (140,219) -> padcol = 0.
REQ-035 Second tick 5 cycles after first -> ignored, single REPORT; assert rst at SCAN idx 7 -> alive = FFFF, score = 0.
REQ-036 Clear all 16 bricks -> without macro all_clear = 1 held; with BRICK_REGEN_EN alive = FFFF after 16th hit, score = 16.
